// File: rtl/regfile_wb_unit.sv
// Register-file write-side driver: merges never-stalling ALU results with
// FIFO-buffered cache load returns and tracks outstanding load destinations.
module regfile_wb_unit #(
  parameter int bit_size = 32,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [4:0]          alu_addr,
  input  logic [bit_size-1:0] alu_data,
  input  logic                ld_issue,
  input  logic [4:0]          ld_issue_addr,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [4:0]          mem_addr,
  input  logic [bit_size-1:0] mem_data,
  output logic                RegWrite,
  output logic [4:0]          Write_addr,
  output logic [bit_size-1:0] Write_data,
  output logic [31:0]         busy_mask
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]          fifo_addr_q [DEPTH];
  logic [bit_size-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;

  logic                reg_write_q, reg_write_d;
  logic [4:0]          write_addr_q, write_addr_d;
  logic [bit_size-1:0] write_data_q, write_data_d;
  logic [31:0]         busy_q, busy_d;

  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [4:0]          head_addr;
  logic [bit_size-1:0] head_data;

  // Ready depends on occupancy only, so a same-cycle pop never frees a slot.
  assign mem_ready  = rst && (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = mem_valid && mem_ready;
  assign pop        = !fifo_empty && !alu_valid;
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      reg_write_d  = (alu_addr != 5'd0);
      write_addr_d = alu_addr;
      write_data_d = alu_data;
    end else if (!fifo_empty) begin
      reg_write_d  = (head_addr != 5'd0);
      write_addr_d = head_addr;
      write_data_d = head_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    // A new load to the same register is outstanding again, so set beats clear.
    if (ld_issue) begin
      busy_d[ld_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates every read, so stale slots are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign RegWrite   = reg_write_q;
  assign Write_addr = write_addr_q;
  assign Write_data = write_data_q;
  assign busy_mask  = busy_q;

endmodule
